// File: rtl/fp32_to_tf32_rne.sv
// fp32_to_tf32_rne: two-stage FP32 to TF32 narrowing converter with RNE rounding and valid/ready flow control
module fp32_to_tf32_rne (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [18:0] out_data,
  output logic        out_ovf,
  output logic        out_uf
);
  typedef enum logic [1:0] {CL_NORM, CL_ZERO, CL_SPEC} cls_t;
  logic        s1_valid_q;
  logic        s1_sign_q;
  logic [7:0]  s1_exp_q;
  logic [9:0]  s1_m_q;
  logic        s1_g_q;
  logic        s1_st_q;
  logic        s1_nz_q;
  cls_t        s1_cls_q;
  cls_t        s1_cls_d;
  logic        out_valid_q;
  logic [18:0] out_data_q;
  logic        out_ovf_q;
  logic        out_uf_q;
  logic [18:0] out_data_d;
  logic        out_ovf_d;
  logic        out_uf_d;
  logic        s1_adv;
  logic        s2_adv;
  logic        up;
  logic [10:0] rnd;
  logic [8:0]  exp9;
  logic        rnd_ovf;
  logic [18:0] sat;
  assign s2_adv    = !out_valid_q || out_ready;
  assign s1_adv    = !s1_valid_q || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign out_uf    = out_uf_q;
  // classify the incoming exponent: zero/subnormal, INF/NaN, or ordinary
  always_comb begin
    s1_cls_d = in_data[30:23] == 8'h00 ? CL_ZERO :
               in_data[30:23] == 8'hFF ? CL_SPEC : CL_NORM;
  end
  // decode stage: split the operand into sign, exponent, kept mantissa, guard and sticky
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= 8'h00;
      s1_m_q     <= 10'h000;
      s1_g_q     <= 1'b0;
      s1_st_q    <= 1'b0;
      s1_nz_q    <= 1'b0;
      s1_cls_q   <= CL_NORM;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sign_q <= in_data[31];
        s1_exp_q  <= in_data[30:23];
        s1_m_q    <= in_data[22:13];
        s1_g_q    <= in_data[12];
        s1_st_q   <= |in_data[11:0];
        s1_nz_q   <= |in_data[22:0];
        s1_cls_q  <= s1_cls_d;
      end
    end
  end
  // round to nearest even; a mantissa carry bumps the exponent and leaves m' at zero
  always_comb begin
    up         = s1_g_q && (s1_st_q || s1_m_q[0]);
    rnd        = {1'b0, s1_m_q} + 11'(up);
    exp9       = {1'b0, s1_exp_q} + 9'(rnd[10]);
    rnd_ovf    = exp9 >= 9'd255;
    sat        = {s1_sign_q, 8'hFE, 10'h3FF};
    out_data_d = s1_cls_q == CL_ZERO ? 19'h00000 :
                 s1_cls_q == CL_SPEC ? sat :
                 rnd_ovf ? sat : {s1_sign_q, exp9[7:0], rnd[9:0]};
    out_ovf_d  = s1_cls_q == CL_SPEC || (s1_cls_q == CL_NORM && rnd_ovf);
    out_uf_d   = s1_cls_q == CL_ZERO && s1_nz_q;
  end
  // output stage: result and flags hold while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 19'h00000;
      out_ovf_q   <= 1'b0;
      out_uf_q    <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q <= out_data_d;
        out_ovf_q  <= out_ovf_d;
        out_uf_q   <= out_uf_d;
      end
    end
  end
endmodule

// File: tb/tb_fp32_to_tf32_rne.sv
// tb_fp32_to_tf32_rne: directed and random checks of the FP32 to TF32 converter against a reference model
module tb_fp32_to_tf32_rne;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [18:0] out_data;
  logic        out_ovf;
  logic        out_uf;
  logic        bp_rand = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_out = 0;
  logic [20:0] sb[$];
  fp32_to_tf32_rne dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf), .out_uf(out_uf)
  );
  always #5 clk = ~clk;
  // reference: classic add-0xFFF-plus-lsb RNE on the raw bit pattern, result {data, ovf, uf}
  function automatic logic [20:0] model(input logic [31:0] x);
    logic [31:0] r;
    logic [18:0] sat;
    sat = {x[31], 8'hFE, 10'h3FF};
    if (x[30:23] == 8'h00) return {19'h00000, 1'b0, |x[22:0]};
    if (x[30:23] == 8'hFF) return {sat, 2'b10};
    r = {1'b0, x[30:0]} + 32'h0000_0FFF + {31'b0, x[13]};
    if (r[30:23] == 8'hFF) return {sat, 2'b10};
    return {x[31], r[30:13], 2'b00};
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [31:0] x);
    int n;
    in_valid = 1'b1;
    in_data  = x;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (n == 50) check("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic drain();
    int n;
    for (n = 0; n < 60; n++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) break;
    end
    check("drain_left", sb.size(), 0);
  endtask
  // scoreboard: push the model result on every accept, pop and compare on every emit
  always @(negedge clk) begin
    logic [20:0] e;
    if (!rst) begin
      if (in_valid && in_ready) sb.push_back(model(in_data));
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) check("unexpected_out", 32'(out_valid), 32'd0);
        else begin
          e = sb.pop_front();
          check("out_data", 32'(out_data), 32'(e[20:2]));
          check("out_ovf", 32'(out_ovf), 32'(e[1]));
          check("out_uf", 32'(out_uf), 32'(e[0]));
        end
      end
    end
  end
  // random consumer backpressure during the soak phase
  always @(posedge clk) begin
    if (bp_rand) #1 out_ready = 1'($urandom_range(0, 1));
  end
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] x;
    logic [20:0] ea;
    int n0;
    int k;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 32'h0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    check("rst_out_uf", 32'(out_uf), 32'd0);
    rst = 1'b0;
    #1 check("rst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data = 32'h3F80_0000;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("lat_cycle1", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 check("lat_cycle2", 32'(out_valid), 32'd1);
    check("one_data", 32'(out_data), 32'h1FC00);
    drain();
    send(32'h3F80_1000);
    send(32'h3F80_3000);
    send(32'h3F80_1001);
    send(32'h3FFF_F000);
    send(32'h7F7F_F000);
    send(32'hFF80_0000);
    send(32'h8000_0000);
    send(32'h0000_0001);
    drain();
    ea = model(32'h4049_0FDB);
    out_ready = 1'b0;
    send(32'h4049_0FDB);
    send(32'hC000_0000);
    in_valid = 1'b1;
    in_data = 32'h3F80_1001;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_hold_data", 32'(out_data), 32'(ea[20:2]));
    end
    out_ready = 1'b1;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    check("bp_resume", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain();
    out_ready = 1'b0;
    send(32'h4000_0000);
    send(32'h4040_0000);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    sb.delete();
    rst = 1'b0;
    out_ready = 1'b1;
    #1 check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    n0 = n_out;
    repeat (5) @(posedge clk);
    #1 check("mid_rst_no_stale", n_out, n0);
    bp_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      x = $urandom;
      if (i % 4 == 0) x[30:23] = 8'hFE;
      if (i % 7 == 0) x[30:23] = 8'h00;
      if (i % 9 == 0) x[30:23] = 8'hFF;
      send(x);
    end
    bp_rand = 1'b0;
    #2 out_ready = 1'b1;
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
